// File: rtl/gate_op_pkg.sv
// Shared definitions for the gate-op arbiter: op code encoding and the
// single-bit gate primitive that the datapath applies across every bit.
package gate_op_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  // Evaluates one bit position and returns {err, y}. It is kept single-bit
  // so that the caller's operand width is free; NOT ignores b, and the
  // reserved code yields y=0 with err set.
  function automatic logic [1:0] gate_eval(input logic [OP_W-1:0] op,
                                           input logic            a,
                                           input logic            b);
    logic y;
    logic err;
    y   = 1'b0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_RSVD: err = 1'b1;
      default: err = 1'b1;
    endcase
    return {err, y};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer, wrapping, and moves the pointer past the winner on advance.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] r_ptr;

  // Scan requests starting at the pointer and pick the first one found.
  always_comb begin : scan
    int  j;
    logic w_found;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_found && req[j]) begin
        w_found   = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  // Pointer moves one past the granted index on an accept, else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      r_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Shares one registered bitwise gate unit between NREQ requesters through
// a round-robin arbiter and a single-entry valid/ready response register.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     rsp_err
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_accept_en;
  logic             w_any;
  logic             w_accept;
  logic [OP_W-1:0]  w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic             w_err;
  logic [1:0]       w_bit;

  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_y;
  logic             r_rsp_err;

  // The output slot can take a new result when empty or being drained.
  assign w_accept_en = !r_rsp_valid || rsp_ready;
  assign w_any       = |req_valid;
  assign w_accept    = w_accept_en && w_any;
  assign req_ready   = {NREQ{w_accept_en}} & w_grant;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Operand mux selects the granted requester's fields.
  assign w_op = req_op[int'(w_grant_idx) * OP_W +: OP_W];
  assign w_a  = req_a[int'(w_grant_idx) * WIDTH +: WIDTH];
  assign w_b  = req_b[int'(w_grant_idx) * WIDTH +: WIDTH];

  // Apply the gate primitive to every bit; err is common to all bits.
  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    w_bit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bit  = gate_eval(w_op, w_a[i], w_b[i]);
      w_y[i] = w_bit[0];
      w_err  = w_err | w_bit[1];
    end
  end

  // Response register: load on accept, clear valid on drain, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept_en) begin
      r_rsp_valid <= w_any;
      if (w_any) begin
        r_rsp_id  <= w_grant_idx;
        r_rsp_y   <= w_y;
        r_rsp_err <= w_err;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Bench for gate_op_arbiter: table-driven op checks, directed multi-cycle
// sequences, and a randomized phase against a transaction-level model.
module tb_gate_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [7:0]        rsp_y;
  logic              rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // Reference: results straight from the op code table.
  function automatic logic [8:0] ref_eval(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, ~a};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, a ^ b};
      3'd6:    return {1'b0, ~(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [7:0] exp_y;
    logic       exp_err;
  } op_vec_t;

  op_vec_t vecs[8];
  logic [7:0] rr_y[4];

  // Transaction-level model state for the random phase.
  bit         m_valid;
  int         m_ptr;
  logic [7:0] m_y;
  int         m_id;
  bit         m_err;

  task automatic rand_cycle();
    bit acc_en;
    int gi;
    int j;
    logic [3:0] exp_ready;
    logic [8:0] r;
    req_valid = 4'($urandom);
    rsp_ready = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'($urandom), 8'($urandom), 8'($urandom));
    #1;
    acc_en = !m_valid || rsp_ready;
    gi = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (gi < 0 && req_valid[j]) gi = j;
    end
    exp_ready = (acc_en && gi >= 0) ? 4'(1 << gi) : 4'h0;
    check("rand req_ready", 32'(req_ready), 32'(exp_ready));
    if (acc_en) begin
      m_valid = (gi >= 0);
      if (gi >= 0) begin
        r     = ref_eval(req_op[3*gi +: 3], req_a[8*gi +: 8], req_b[8*gi +: 8]);
        m_y   = r[7:0];
        m_err = r[8];
        m_id  = gi;
        m_ptr = (gi + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
    check("rand rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rand rsp_y", 32'(rsp_y), 32'(m_y));
      check("rand rsp_id", 32'(rsp_id), 32'(m_id));
      check("rand rsp_err", 32'(rsp_err), 32'(m_err));
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h30, 1'b0};
    vecs[1] = '{3'd1, 8'hFC, 1'b0};
    vecs[2] = '{3'd2, 8'h0F, 1'b0};
    vecs[3] = '{3'd3, 8'hCF, 1'b0};
    vecs[4] = '{3'd4, 8'h03, 1'b0};
    vecs[5] = '{3'd5, 8'hCC, 1'b0};
    vecs[6] = '{3'd6, 8'h33, 1'b0};
    vecs[7] = '{3'd7, 8'h00, 1'b1};
    rr_y[0] = 8'h30;
    rr_y[1] = 8'hFC;
    rr_y[2] = 8'h0F;
    rr_y[3] = 8'hCF;

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_y", 32'(rsp_y), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    // Op table on requester 0, a=F0 b=3C.
    for (int v = 0; v < 8; v++) begin
      req_valid = 4'b0001;
      set_req(0, vecs[v].op, 8'hF0, 8'h3C);
      #1;
      check("op req_ready", 32'(req_ready), 32'h1);
      tick();
      check("op rsp_valid", 32'(rsp_valid), 32'd1);
      check("op rsp_y", 32'(rsp_y), 32'(vecs[v].exp_y));
      check("op rsp_err", 32'(rsp_err), 32'(vecs[v].exp_err));
      check("op rsp_id", 32'(rsp_id), 32'd0);
    end

    // Reset mid-stream: outputs clear immediately, pointer back to 0.
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 8'hF0, 8'h3C);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst rsp_y", 32'(rsp_y), 32'd0);
    check("midrst rsp_id", 32'(rsp_id), 32'd0);
    check("midrst req_ready ptr0", 32'(req_ready), 32'h1);
    tick();
    rst_n = 1'b1;

    // Round-robin with all four valid.
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr req_ready", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
      check("rr rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr rsp_id", 32'(rsp_id), 32'(c % 4));
      check("rr rsp_y", 32'(rsp_y), 32'(rr_y[c % 4]));
    end

    // Stall five cycles with only requester 1 valid; held response is id3/CF.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      set_req(1, 3'($urandom), 8'($urandom), 8'($urandom));
      #1;
      check("stall req_ready", 32'(req_ready), 32'h0);
      tick();
      check("stall rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall rsp_id", 32'(rsp_id), 32'd3);
      check("stall rsp_y", 32'(rsp_y), 32'hCF);
    end
    set_req(1, 3'd1, 8'hF0, 8'h3C);
    rsp_ready = 1'b1;
    #1;
    check("release req_ready", 32'(req_ready), 32'h2);
    tick();
    check("release rsp_id", 32'(rsp_id), 32'd1);
    check("release rsp_y", 32'(rsp_y), 32'hFC);

    // Wrap and skip: move ptr to 3, then only req0 and req2 valid.
    req_valid = 4'b0100;
    tick();
    check("wrap pre id", 32'(rsp_id), 32'd2);
    req_valid = 4'b0101;
    #1;
    check("wrap req_ready 0", 32'(req_ready), 32'h1);
    tick();
    check("wrap id 0", 32'(rsp_id), 32'd0);
    check("wrap y 0", 32'(rsp_y), 32'h30);
    #1;
    check("wrap req_ready 2", 32'(req_ready), 32'h4);
    tick();
    check("wrap id 2", 32'(rsp_id), 32'd2);
    check("wrap y 2", 32'(rsp_y), 32'h0F);

    // Idle drain: one request then none.
    req_valid = 4'b1000;
    tick();
    check("drain valid hi", 32'(rsp_valid), 32'd1);
    check("drain id", 32'(rsp_id), 32'd3);
    req_valid = 4'b0000;
    #1;
    check("drain no grant", 32'(req_ready), 32'h0);
    tick();
    check("drain valid lo", 32'(rsp_valid), 32'd0);
    tick();
    check("drain stays lo", 32'(rsp_valid), 32'd0);

    // Randomized phase against the model, from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_ptr   = 0;
    m_y     = '0;
    m_id    = 0;
    m_err   = 1'b0;
    for (int n = 0; n < 400; n++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
